// File: rtl/nmr_pulse_sequencer_if.sv
// nmr_pulse_sequencer_if
//   Groups the pulse sequencer's trigger, per-sequence configuration and
//   shot outputs into one bundle. The clock and reset stay plain module ports.
//   master : the host side. It drives the trigger and config, and observes the gates.
//   slave  : the sequencer side.
//   Signals
//     sync_pulse  phase-aligned trigger (level)
//     abort       synchronous sequence abort
//     tx_width    TX gate length (cycles)
//     dead_time   TX-to-acquisition gap (cycles)
//     acq_width   acquisition window length (cycles)
//     rep_period  shot-start to shot-start period (cycles)
//     num_shots   shots per sequence
//     tx_gate     RF transmit enable
//     acq_gate    ADC capture enable
//     busy        sequence in progress
//     done        one-cycle end-of-sequence pulse
//     shot_count  shots completed in the current or last sequence
interface nmr_pulse_sequencer_if #(
  parameter int CNT_W = 32,
  parameter int NUM_W = 16
);
  logic             sync_pulse;
  logic             abort;
  logic [CNT_W-1:0] tx_width;
  logic [CNT_W-1:0] dead_time;
  logic [CNT_W-1:0] acq_width;
  logic [CNT_W-1:0] rep_period;
  logic [NUM_W-1:0] num_shots;
  logic             tx_gate;
  logic             acq_gate;
  logic             busy;
  logic             done;
  logic [NUM_W-1:0] shot_count;

  modport master (
    output sync_pulse, abort, tx_width, dead_time, acq_width, rep_period, num_shots,
    input  tx_gate, acq_gate, busy, done, shot_count
  );

  modport slave (
    input  sync_pulse, abort, tx_width, dead_time, acq_width, rep_period, num_shots,
    output tx_gate, acq_gate, busy, done, shot_count
  );
endinterface

// File: rtl/nmr_pulse_sequencer.sv
// nmr_pulse_sequencer
//   A rising edge of sync_pulse seen in IDLE starts a train of num_shots shots.
//   Each shot is made up of:
//     - a TX gate,
//     - a dead time,
//     - an acquisition window,
//     - idle time until the shot length L expires.
//   L = max(rep_period, tx+dead+acq, 1).
//   The configuration is captured at the start edge, so later input changes are
//   ignored until the next sequence. All outputs are registered, and the first
//   shot cycle (t=0) is the cycle after the start edge.
//   Ports
//     clk  system clock
//     rst  asynchronous reset, active low
//     bus  nmr_pulse_sequencer_if.slave: trigger, abort, config in; gates and status out
module nmr_pulse_sequencer #(
  parameter int CNT_W = 32,
  parameter int NUM_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  nmr_pulse_sequencer_if.slave  bus
);

  // The timer and window bounds carry two extra bits so that tx+dead+acq never wraps.
  localparam int T_W = CNT_W + 2;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_nx;
  logic             sync_d;
  logic [CNT_W-1:0] tx_q, dead_q, acq_q, rep_q;
  logic [NUM_W-1:0] num_q;
  logic [T_W-1:0]   t_q, t_nx;
  logic [NUM_W-1:0] cnt_q;
  logic             tx_r, acq_r, busy_r, done_r;
  logic             tx_nx, acq_nx, busy_nx, done_nx;

  logic             start;
  logic             shot_end;
  logic             last_shot;
  logic [NUM_W:0]   cnt_inc;

  // Config in force for the cycle being computed: at the start edge the live
  // inputs, otherwise the captured shadow copy.
  logic [CNT_W-1:0] tx_e, dead_e, acq_e, rep_e;
  logic [T_W-1:0]   tx_x, acq_lo, acq_hi, rep_x, len;

  // abort has priority over a coincident start.
  assign start = (state_q == IDLE) && bus.sync_pulse && !sync_d && !bus.abort;

  assign tx_e   = start ? bus.tx_width   : tx_q;
  assign dead_e = start ? bus.dead_time  : dead_q;
  assign acq_e  = start ? bus.acq_width  : acq_q;
  assign rep_e  = start ? bus.rep_period : rep_q;

  assign tx_x   = T_W'(tx_e);
  assign acq_lo = tx_x + T_W'(dead_e);
  assign acq_hi = acq_lo + T_W'(acq_e);
  assign rep_x  = T_W'(rep_e);

  always_comb begin
    len = rep_x;
    if (acq_hi > len) len = acq_hi;
    if (len == '0)    len = T_W'(1);
  end

  assign shot_end  = (state_q == RUN) && (t_q == len - T_W'(1));
  assign cnt_inc   = {1'b0, cnt_q} + (NUM_W+1)'(1);
  assign last_shot = (cnt_inc == {1'b0, num_q});

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      t_q     <= '0;
    end else begin
      state_q <= state_nx;
      t_q     <= t_nx;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_nx = state_q;
    t_nx     = t_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          t_nx     = '0;
          state_nx = (bus.num_shots == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_nx = DONE;
          t_nx     = '0;
        end else if (shot_end) begin
          t_nx = '0;
          if (last_shot) state_nx = DONE;
        end else begin
          t_nx = t_q + T_W'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
        t_nx     = '0;
      end
      default: begin
        state_nx = IDLE;
        t_nx     = '0;
      end
    endcase
  end

  // ------------------------------------------------------------------ outputs
  // Each output is computed from the next state and timer, then registered, so
  // the gates line up with the timer value held in the same cycle.
  always_comb begin
    busy_nx = (state_nx == RUN);
    done_nx = (state_nx == DONE);
    tx_nx   = busy_nx && (t_nx < tx_x);
    acq_nx  = busy_nx && (t_nx >= acq_lo) && (t_nx < acq_hi);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_r   <= 1'b0;
      acq_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      tx_r   <= tx_nx;
      acq_r  <= acq_nx;
      busy_r <= busy_nx;
      done_r <= done_nx;
    end
  end

  // ----------------------------------------------- trigger, shadow, shot count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_d <= 1'b0;
      tx_q   <= '0;
      dead_q <= '0;
      acq_q  <= '0;
      rep_q  <= '0;
      num_q  <= '0;
      cnt_q  <= '0;
    end else begin
      sync_d <= bus.sync_pulse;
      if (start) begin
        tx_q   <= bus.tx_width;
        dead_q <= bus.dead_time;
        acq_q  <= bus.acq_width;
        rep_q  <= bus.rep_period;
        num_q  <= bus.num_shots;
        cnt_q  <= '0;
      end else if (shot_end && !bus.abort && (cnt_q != '1)) begin
        // An aborted partial shot is not counted.
        cnt_q <= cnt_q + NUM_W'(1);
      end
    end
  end

  assign bus.tx_gate    = tx_r;
  assign bus.acq_gate   = acq_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.shot_count = cnt_q;

endmodule

// File: tb/tb_nmr_pulse_sequencer.sv
// tb_nmr_pulse_sequencer
//   The driver issues sequences, both directed and random, and pushes the
//   expected outcome of each sequence into a queue. That outcome is computed
//   from the shot-length arithmetic.
//   A negedge monitor accumulates gate and busy activity. On every done pulse it
//   pops one expectation and compares against it.
module tb_nmr_pulse_sequencer;
  localparam int CNT_W = 32;
  localparam int NUM_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nmr_pulse_sequencer_if #(.CNT_W(CNT_W), .NUM_W(NUM_W)) bus ();
  nmr_pulse_sequencer #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    longint done_cyc;
    longint first_busy;  // -1: no run expected
    longint first_rise;  // -1: no TX rise expected
    longint gap;         // -1: spacing not checked
    longint busy_n;
    longint tx_n;
    longint acq_n;
    longint shots;
  } exp_t;

  exp_t   q[$];
  int     checks = 0;
  int     passed = 0;
  longint cyc = 0;
  int     done_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // ---------------------------------------------------------------- monitor
  longint busy_n, tx_n, acq_n, ovl, first_busy, rise1, rise2;
  bit     busy_p, tx_p;
  exp_t   ex;

  task automatic clr_acc();
    busy_n = 0; tx_n = 0; acq_n = 0; ovl = 0;
    first_busy = -1; rise1 = -1; rise2 = -1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      clr_acc();
      busy_p = 1'b0;
      tx_p   = 1'b0;
    end else begin
      if (bus.busy && !busy_p) begin
        first_busy = cyc;
        chk("count_at_start", longint'(bus.shot_count), 0);
      end
      if (bus.busy) busy_n++;
      if (bus.tx_gate) tx_n++;
      if (bus.acq_gate) acq_n++;
      if (bus.tx_gate && bus.acq_gate) ovl++;
      if ((bus.tx_gate || bus.acq_gate) && !bus.busy) ovl++;
      if (bus.tx_gate && !tx_p) begin
        if (rise1 < 0) rise1 = cyc;
        else if (rise2 < 0) rise2 = cyc;
      end
      busy_p = bus.busy;
      tx_p   = bus.tx_gate;
      if (bus.done) begin
        done_seen++;
        chk("busy_low_at_done", longint'(bus.busy), 0);
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          ex = q.pop_front();
          chk("done_cycle", cyc, ex.done_cyc);
          chk("shot_count", longint'(bus.shot_count), ex.shots);
          chk("busy_cycles", busy_n, ex.busy_n);
          chk("tx_cycles", tx_n, ex.tx_n);
          chk("acq_cycles", acq_n, ex.acq_n);
          chk("gate_overlap", ovl, 0);
          if (ex.first_busy >= 0) chk("first_busy", first_busy, ex.first_busy);
          if (ex.first_rise >= 0) chk("first_tx_rise", rise1, ex.first_rise);
          if (ex.gap >= 0) chk("tx_rise_gap", rise2 - rise1, ex.gap);
        end
        clr_acc();
      end
    end
  end

  // ----------------------------------------------------------------- driver
  // ab: index of the RUN cycle that carries abort (-1: none). hold: keep
  // sync_pulse high after the sequence and confirm it does not retrigger.
  task automatic run_seq(input longint tx, input longint dead, input longint acq,
                         input longint rep, input longint n, input longint ab,
                         input bit hold);
    exp_t   e;
    longint len, total, r, e0, lim;
    int     ds, bcnt;
    if (bus.sync_pulse) begin
      @(posedge clk); #1;
      bus.sync_pulse = 1'b0;
    end
    @(posedge clk); #1;
    bus.tx_width   = CNT_W'(tx);
    bus.dead_time  = CNT_W'(dead);
    bus.acq_width  = CNT_W'(acq);
    bus.rep_period = CNT_W'(rep);
    bus.num_shots  = NUM_W'(n);
    bus.sync_pulse = 1'b1;
    e0 = cyc;
    ds = done_seen;

    len = rep;
    if (tx + dead + acq > len) len = tx + dead + acq;
    if (len < 1) len = 1;
    total = (n == 0) ? 0 : ((ab >= 0) ? ab + 1 : n * len);
    r = total % len;
    e.done_cyc   = e0 + 1 + total;
    e.first_busy = (n > 0) ? e0 + 1 : -1;
    e.first_rise = (n > 0 && tx > 0) ? e0 + 1 : -1;
    e.gap        = (tx > 0 && tx < len && total > len) ? len : -1;
    e.busy_n     = total;
    e.shots      = (n == 0) ? 0 : ((ab >= 0) ? ab / len : n);
    e.tx_n       = (total / len) * tx + ((r < tx) ? r : tx);
    e.acq_n      = (total / len) * acq;
    if (r > tx + dead) e.acq_n += ((r < tx + dead + acq) ? r : tx + dead + acq) - (tx + dead);
    q.push_back(e);

    // Scramble the live config once the start edge has passed.
    @(posedge clk); #1;
    bus.tx_width   = CNT_W'($urandom_range(0, 60));
    bus.dead_time  = CNT_W'($urandom_range(0, 30));
    bus.acq_width  = CNT_W'($urandom_range(0, 60));
    bus.rep_period = CNT_W'($urandom_range(0, 200));
    bus.num_shots  = NUM_W'($urandom_range(0, 9));

    if (ab >= 0) begin
      while (cyc < e0 + 1 + ab) begin
        @(posedge clk); #1;
      end
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
    end

    lim = total + 50;
    for (longint k = 0; k < lim && done_seen == ds; k++) @(posedge clk);
    chk("done_arrived", longint'(done_seen != ds), 1);
    #1;
    if (hold) begin
      bcnt = 0;
      for (int k = 0; k < 30; k++) begin
        @(posedge clk); #1;
        if (bus.busy || bus.done) bcnt++;
      end
      chk("no_retrigger", bcnt, 0);
    end else begin
      bus.sync_pulse = 1'b0;
    end
  endtask

  initial begin
    longint rtx, rdead, racq, rrep, rn, rab, rlen;
    int     bcnt;
    bus.sync_pulse = 1'b0;
    bus.abort      = 1'b0;
    bus.tx_width   = '0;
    bus.dead_time  = '0;
    bus.acq_width  = '0;
    bus.rep_period = '0;
    bus.num_shots  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", longint'(bus.tx_gate), 0);
    chk("rst_acq", longint'(bus.acq_gate), 0);
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_done", longint'(bus.done), 0);
    chk("rst_count", longint'(bus.shot_count), 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    run_seq(10, 5, 20, 100, 3, -1, 1'b1);  // basic train, then hold trigger high
    run_seq(10, 5, 20, 100, 3, -1, 1'b0);  // re-raise: second run
    run_seq(50, 5, 20, 100, 2, -1, 1'b0);  // new tx width only on next sequence
    run_seq(10, 5, 20, 10, 3, -1, 1'b0);   // rep shorter than windows -> L=35
    run_seq(10, 5, 20, 100, 3, 120, 1'b0); // abort in shot 2 acquisition
    run_seq(0, 0, 0, 0, 4, -1, 1'b0);      // L=1, no gates
    run_seq(5, 3, 4, 20, 0, -1, 1'b0);     // zero shots: done only

    // abort together with the trigger edge: no sequence starts
    @(posedge clk); #1;
    bus.num_shots  = NUM_W'(2);
    bus.sync_pulse = 1'b1;
    bus.abort      = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    bcnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (bus.busy || bus.done) bcnt++;
    end
    chk("abort_beats_start", bcnt, 0);
    bus.sync_pulse = 1'b0;

    // asynchronous reset in the middle of the TX gate
    @(posedge clk); #1;
    bus.tx_width   = CNT_W'(10);
    bus.dead_time  = CNT_W'(5);
    bus.acq_width  = CNT_W'(20);
    bus.rep_period = CNT_W'(100);
    bus.num_shots  = NUM_W'(3);
    bus.sync_pulse = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("tx_before_reset", longint'(bus.tx_gate), 1);
    #2 rst = 1'b0;
    #1;
    chk("reset_tx", longint'(bus.tx_gate), 0);
    chk("reset_busy", longint'(bus.busy), 0);
    chk("reset_count", longint'(bus.shot_count), 0);
    repeat (2) @(posedge clk);
    #1;
    bus.sync_pulse = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 25; i++) begin
      rtx   = longint'($urandom_range(0, 12));
      rdead = longint'($urandom_range(0, 6));
      racq  = longint'($urandom_range(0, 15));
      rrep  = longint'($urandom_range(0, 40));
      rn    = longint'($urandom_range(0, 4));
      rlen  = rrep;
      if (rtx + rdead + racq > rlen) rlen = rtx + rdead + racq;
      if (rlen < 1) rlen = 1;
      rab = -1;
      if (rn > 0 && ($urandom_range(0, 2) == 0)) rab = longint'($urandom) % (rn * rlen);
      run_seq(rtx, rdead, racq, rrep, rn, rab, 1'b0);
    end

    repeat (5) @(posedge clk);
    chk("queue_drained", longint'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
